// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with per-register busy scoreboard
// Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 hardwired to zero, no storage flop)
module reg_file_mp #(
    parameter  int WORD      = 8,
    parameter  int REG_SIZE  = 4,
    parameter  int NUM_RD    = 2,
    localparam int ADDR_SIZE = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_RD*ADDR_SIZE-1:0] i_rd_addr,
    output logic [NUM_RD*WORD-1:0]      o_rd_data,
    output logic [NUM_RD-1:0]           o_rd_busy,
    input  logic                        i_wr_en,
    input  logic [ADDR_SIZE-1:0]        i_wr_addr,
    input  logic [WORD-1:0]             i_wr_data,
    input  logic                        i_lock_en,
    input  logic [ADDR_SIZE-1:0]        i_lock_addr,
    output logic                        o_any_busy
);

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // Addresses are compared at full width, so non-power-of-two depths
    // leave a window of unused codes that must be ignored.
    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return ({{(32-ADDR_SIZE){1'b0}}, a} < 32'(REG_SIZE));
    endfunction

    logic                     w_wr_hit;
    logic                     w_lock_hit;
    logic [WORD-1:0]          w_regs [REG_SIZE];
    logic [REG_SIZE-1:0]      r_busy;
    logic [REG_SIZE-1:0]      w_busy_next;
    logic [ADDR_SIZE-1:0]     w_ra;
    logic [NUM_RD*WORD-1:0]   w_rd_data_next;
    logic [NUM_RD-1:0]        w_rd_busy_next;
    logic [NUM_RD*WORD-1:0]   r_rd_data;
    logic [NUM_RD-1:0]        r_rd_busy;
    logic                     r_any_busy;

    // A hardwired register 0 rejects both writes and locks, which also
    // keeps it out of the bypass path.
    assign w_wr_hit   = i_wr_en && in_range(i_wr_addr) &&
                        !(ZERO_REG && (i_wr_addr == '0));
    assign w_lock_hit = i_lock_en && in_range(i_lock_addr) &&
                        !(ZERO_REG && (i_lock_addr == '0));

    for (genvar g = 0; g < REG_SIZE; g++) begin : g_reg
        if (ZERO_REG && (g == 0)) begin : g_zero
            assign w_regs[g] = '0;
        end else begin : g_store
            logic [WORD-1:0] r_word;
            // Capture write data when this register is the write target
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_word <= '0;
                end else if (w_wr_hit && (i_wr_addr == ADDR_SIZE'(g))) begin
                    r_word <= i_wr_data;
                end
            end
            assign w_regs[g] = r_word;
        end
    end

    // Busy state after this edge: a write clears, a lock sets, lock applied last so it wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_hit) begin
            w_busy_next[i_wr_addr] = 1'b0;
        end
        if (w_lock_hit) begin
            w_busy_next[i_lock_addr] = 1'b1;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Per-port read selection with write-first bypass; out-of-range ports read zero, not busy
    always_comb begin
        w_rd_data_next = '0;
        w_rd_busy_next = '0;
        w_ra           = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = i_rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
            if (in_range(w_ra)) begin
                if (w_wr_hit && (i_wr_addr == w_ra)) begin
                    w_rd_data_next[i*WORD +: WORD] = i_wr_data;
                end else begin
                    w_rd_data_next[i*WORD +: WORD] = w_regs[w_ra];
                end
                w_rd_busy_next[i] = w_busy_next[w_ra];
            end
        end
    end

    // Registered read outputs and aggregate busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_busy  <= '0;
            r_any_busy <= 1'b0;
        end else begin
            r_rd_data  <= w_rd_data_next;
            r_rd_busy  <= w_rd_busy_next;
            r_any_busy <= |w_busy_next;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_busy  = r_rd_busy;
    assign o_any_busy = r_any_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp against an array-based model
module tb_reg_file_mp;

    localparam int WORD     = 8;
    localparam int REG_SIZE = 5;
    localparam int NUM_RD   = 2;
    localparam int AW       = 3;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic [NUM_RD*AW-1:0]   i_rd_addr;
    logic [NUM_RD*WORD-1:0] o_rd_data;
    logic [NUM_RD-1:0]      o_rd_busy;
    logic                   i_wr_en;
    logic [AW-1:0]          i_wr_addr;
    logic [WORD-1:0]        i_wr_data;
    logic                   i_lock_en;
    logic [AW-1:0]          i_lock_addr;
    logic                   o_any_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] m_mem  [REG_SIZE];
    bit         m_busy [REG_SIZE];

    reg_file_mp #(.WORD(WORD), .REG_SIZE(REG_SIZE), .NUM_RD(NUM_RD)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_rd_busy   (o_rd_busy),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_lock_en   (i_lock_en),
        .i_lock_addr (i_lock_addr),
        .o_any_busy  (o_any_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < REG_SIZE; k++) begin
            m_mem[k]  = 8'h00;
            m_busy[k] = 1'b0;
        end
    endtask

    function automatic bit target_ok(input logic [2:0] a);
        return (int'(a) < REG_SIZE) && !(ZERO && (a == 3'd0));
    endfunction

    function automatic logic [7:0] exp_data(input logic [2:0] a);
        return (int'(a) < REG_SIZE) ? m_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_busy(input logic [2:0] a);
        return (int'(a) < REG_SIZE) ? {7'd0, m_busy[a]} : 8'h00;
    endfunction

    function automatic logic [7:0] exp_any();
        bit b = 1'b0;
        for (int k = 0; k < REG_SIZE; k++) b |= m_busy[k];
        return {7'd0, b};
    endfunction

    task automatic check_outputs(input string tag, input logic [2:0] ra0, input logic [2:0] ra1);
        chk({tag, "_d0"}, o_rd_data[7:0],  exp_data(ra0));
        chk({tag, "_d1"}, o_rd_data[15:8], exp_data(ra1));
        chk({tag, "_b0"}, {7'd0, o_rd_busy[0]}, exp_busy(ra0));
        chk({tag, "_b1"}, {7'd0, o_rd_busy[1]}, exp_busy(ra1));
        chk({tag, "_any"}, {7'd0, o_any_busy}, exp_any());
    endtask

    // One clock of stimulus; the model applies write then lock, so reads of
    // the updated model naturally express write-first bypass and lock-wins.
    task automatic step(input string tag, input bit we, input logic [2:0] wa,
                        input logic [7:0] wd, input bit le, input logic [2:0] la,
                        input logic [2:0] ra0, input logic [2:0] ra1);
        i_wr_en     = we;
        i_wr_addr   = wa;
        i_wr_data   = wd;
        i_lock_en   = le;
        i_lock_addr = la;
        i_rd_addr   = {ra1, ra0};
        if (we && target_ok(wa)) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (le && target_ok(la)) begin
            m_busy[la] = 1'b1;
        end
        @(posedge i_clk);
        #1;
        check_outputs(tag, ra0, ra1);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_wr_en     = 1'b0;
        i_wr_addr   = '0;
        i_wr_data   = '0;
        i_lock_en   = 1'b0;
        i_lock_addr = '0;
        i_rd_addr   = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs("reset", 3'd0, 3'd0);
        i_rst_n = 1'b1;

        // Write then lock r1, then reset asynchronously between edges
        step("t1_wr",   1, 3'd1, 8'hA5, 0, 3'd0, 3'd1, 3'd1);
        step("t1_lock", 0, 3'd0, 8'h00, 1, 3'd1, 3'd1, 3'd1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_async_d0",  o_rd_data[7:0], 8'h00);
        chk("t1_async_b0",  {7'd0, o_rd_busy[0]}, 8'h00);
        chk("t1_async_any", {7'd0, o_any_busy}, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("t1_rd", 0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd1);

        // Both ports reading the same register
        step("t2_wr", 1, 3'd2, 8'h3C, 0, 3'd0, 3'd0, 3'd0);
        step("t2_rd", 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd2);

        // Bypass on port 0 while port 1 reads r0
        step("t3_byp", 1, 3'd3, 8'hFF, 0, 3'd0, 3'd3, 3'd0);

        // Scoreboard set/clear and lock-wins
        step("t4_lock", 0, 3'd0, 8'h00, 1, 3'd1, 3'd0, 3'd2);
        step("t4_rd",   0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd1);
        step("t4_wr",   1, 3'd1, 8'h11, 0, 3'd0, 3'd1, 3'd1);
        step("t4_lw",   1, 3'd1, 8'h22, 1, 3'd1, 3'd1, 3'd1);
        step("t4_rd2",  0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd3);
        step("t4_diff", 1, 3'd1, 8'h44, 1, 3'd4, 3'd1, 3'd4);

        // Out-of-range write/lock/read, then sweep every register
        step("t5_oor", 1, 3'd6, 8'h77, 1, 3'd6, 3'd7, 3'd5);
        step("t5_s01", 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd1);
        step("t5_s23", 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd3);
        step("t5_s47", 0, 3'd0, 8'h00, 0, 3'd0, 3'd4, 3'd7);

        // Register 0 write and lock, with same-cycle bypass
        step("t6_wl", 1, 3'd0, 8'h55, 1, 3'd0, 3'd0, 3'd0);
        step("t6_rd", 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd6);

        // Randomized traffic over the full address code space
        for (int n = 0; n < 300; n++) begin
            step("rnd",
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file with a per-register busy scoreboard.
- Next generation of the core's 2-read/1-write register file: generalised word width, depth and read-port count.
- Adds asynchronous reset, write-to-read bypass and out-of-range address handling.
- Tracks outstanding writes so the decode stage can stall on read-after-write hazards.

Parameters:
- WORD, 8, data width in bits.
- REG_SIZE, 4, number of registers; need not be a power of two.
- NUM_RD, 2, number of read ports, 1..8.
- ADDR_SIZE (localparam), $clog2(REG_SIZE) with a minimum of 1, address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_RD*ADDR_SIZE  packed read addresses; port i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
- rd_data  output  NUM_RD*WORD  packed registered read data, same packing.
- rd_busy  output  NUM_RD  registered busy flag of each addressed register.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_SIZE  write address.
- wr_data  input  WORD  write data.
- lock_en  input  1  mark a register as having a pending write.
- lock_addr  input  ADDR_SIZE  register to lock.
- any_busy  output  1  registered OR of all busy bits.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, asynchronously clear every register, every busy bit, rd_data, rd_busy and any_busy to 0. Reset mid-operation discards pending locks and writes. First write is accepted on the first rising edge with rst_n=1.
- Storage: REG_SIZE x WORD flops, no RAM inference required.
- Write: at posedge, if wr_en=1 and wr_addr<REG_SIZE, then registry[wr_addr]<=wr_data and busy[wr_addr]<=0. If wr_addr>=REG_SIZE, the write is ignored.
- Lock: at posedge, if lock_en=1 and lock_addr<REG_SIZE, then busy[lock_addr]<=1.
- Lock and write to the same address in one cycle: the lock wins, busy=1, data is still written (new producer issued). Lock and write to different addresses: both take effect.
- Read: latency 1 cycle, registered. At posedge, for each port i: rd_data_i <= (wr_en && wr_addr==rd_addr_i && in range) ? wr_data : registry[rd_addr_i].
  - Write-first bypass; every port bypasses independently.
  - Any number of ports may read the same address.
- rd_busy_i is registered from busy_next[rd_addr_i], i.e. the busy state after that edge's lock and write updates, consistent with the bypass.
- Out-of-range read address: rd_data_i<=0 and rd_busy_i<=0.
- any_busy is registered from the OR of busy_next.
- No other state: the block has no FSM beyond the busy-bit vector. Each busy bit transitions 0->1 on lock and 1->0 on write; lock on an already-busy register keeps it busy.
- Widths: no arithmetic; address compares use the full ADDR_SIZE bits.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero.
  - Writes to address 0 are ignored, including the bypass path.
  - Locks to address 0 are ignored.
  - Reads of address 0 return 0 with rd_busy=0.
  - Register 0 holds no storage flop.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset/async: write 8'hA5 to r1, read it back. Assert rst_n=0 between clock edges; rd_data and any_busy go to 0 immediately without an edge. Release, read r1 -> 8'h00.
2. Basic write/read, NUM_RD=2: write r2=8'h3C. On the next cycle set rd_addr port0=2, port1=2 -> both rd_data=8'h3C one cycle later.
3. Bypass: in the same cycle, wr_en=1, wr_addr=3, wr_data=8'hFF and rd_addr port0=3 -> rd_data port0=8'hFF at the next edge. Port1 reading r0 is unaffected.
4. Scoreboard:
   - lock r1; next cycle read r1 -> rd_busy=1, any_busy=1.
   - write r1=8'h11 -> the bypass read shows rd_busy=0, data 8'h11, any_busy=0.
   - Simultaneous lock+write r1 -> busy stays 1, data updated.
5. Out of range, REG_SIZE=5: write address 6 with 8'h77 -> no register changes. Read address 7 -> rd_data=0, rd_busy=0.
6. With REG_FILE_ZERO_REG_EN: write r0=8'h55 and lock r0 -> read r0 gives 0, not busy, including the same-cycle bypass. Without the macro -> 8'h55 and busy=1.
